// File: rtl/pb_event.sv
// Push-button gesture decoder: turns a debounced button level into single-cycle
// press/release/click/double-click/long/repeat pulses timed in prescaled ticks.
module pb_event #(
    parameter int unsigned TICK_DIV     = 48000,
    parameter int unsigned LONG_TICKS   = 750,
    parameter int unsigned DCLICK_TICKS = 250,
    parameter int unsigned REPEAT_TICKS = 100,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clean_pb,
    output logic held,
    output logic press_p,
    output logic release_p,
    output logic click_p,
    output logic dclick_p,
    output logic long_p,
    output logic repeat_p
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_LONG,
        ST_WAIT2,
        ST_SECOND
    } state_t;

    localparam logic [15:0] PRESC_LAST  = 16'(TICK_DIV - 1);
    localparam logic [9:0]  LONG_LAST   = 10'(LONG_TICKS - 1);
    localparam logic [9:0]  DCLICK_LAST = 10'(DCLICK_TICKS - 1);
    localparam logic [9:0]  REPEAT_LAST = 10'(REPEAT_TICKS - 1);

    state_t      state_q, state_d;
    logic        smp_q, smp_d;
    logic        btn_q, btn_d;
    logic [15:0] presc_q, presc_d;
    logic [9:0]  tcnt_q, tcnt_d;
    logic        held_q, held_d;
    logic        press_q, press_d;
    logic        release_q, release_d;
    logic        click_q, click_d;
    logic        dclick_q, dclick_d;
    logic        long_q, long_d;
    logic        repeat_q, repeat_d;

    logic btn, rise, fall, tick, moved;

    // smp_q is the sampling stage; edges are detected between it and btn_q so
    // every pulse lands two clocks after the input changes.
    always_comb begin
        smp_d     = clean_pb ^ ACTIVE_LOW;
        btn       = smp_q;
        btn_d     = btn;
        rise      = btn & ~btn_q;
        fall      = ~btn & btn_q;
        tick      = (presc_q == '0);

        state_d   = state_q;
        click_d   = 1'b0;
        dclick_d  = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise) state_d = ST_PRESSED;
            end
            ST_PRESSED: begin
                if (fall) begin
                    state_d = ST_WAIT2;
                end else if (tick && tcnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = ST_LONG;
                end
            end
            ST_LONG: begin
                if (fall) begin
                    state_d = ST_IDLE;
                end else if (tick && tcnt_q == REPEAT_LAST) begin
                    repeat_d = 1'b1;
                end
            end
            ST_WAIT2: begin
                if (rise) begin
                    dclick_d = 1'b1;
                    state_d  = ST_SECOND;
                end else if (tick && tcnt_q == DCLICK_LAST) begin
                    click_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_SECOND: begin
                if (fall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        moved   = (state_d != state_q);
        presc_d = (moved || tick) ? PRESC_LAST : presc_q - 16'd1;

        // Idle and second-press states can last forever, so the count saturates.
        if (moved || repeat_d) begin
            tcnt_d = '0;
        end else if (tick && tcnt_q != '1) begin
            tcnt_d = tcnt_q + 10'd1;
        end else begin
            tcnt_d = tcnt_q;
        end

        held_d    = btn;
        press_d   = rise;
        release_d = fall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            smp_q     <= 1'b0;
            btn_q     <= 1'b0;
            presc_q   <= PRESC_LAST;
            tcnt_q    <= '0;
            held_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            dclick_q  <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            smp_q     <= smp_d;
            btn_q     <= btn_d;
            presc_q   <= presc_d;
            tcnt_q    <= tcnt_d;
            held_q    <= held_d;
            press_q   <= press_d;
            release_q <= release_d;
            click_q   <= click_d;
            dclick_q  <= dclick_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    assign held      = held_q;
    assign press_p   = press_q;
    assign release_p = release_q;
    assign click_p   = click_q;
    assign dclick_p  = dclick_q;
    assign long_p    = long_q;
    assign repeat_p  = repeat_q;

endmodule

// File: tb/tb_pb_event.sv
// Bench for pb_event: a timestamp-based gesture model predicts every output
// cycle by cycle for an active-low and an active-high instance.
module tb_pb_event;

    localparam int DIV = 4;
    localparam int LT  = 10;
    localparam int DT  = 5;
    localparam int RT  = 3;

    localparam int B_REP   = 0;
    localparam int B_LONG  = 1;
    localparam int B_DCLK  = 2;
    localparam int B_CLICK = 3;
    localparam int B_REL   = 4;
    localparam int B_PRESS = 5;
    localparam int B_HELD  = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pb_n = 1'b1;
    logic pb = 1'b0;

    logic held_a, press_a, release_a, click_a, dclick_a, long_a, repeat_a;
    logic held_b, press_b, release_b, click_b, dclick_b, long_b, repeat_b;
    logic [6:0] obs_a, obs_b;

    always #5 clk = ~clk;

    pb_event #(.TICK_DIV(DIV), .LONG_TICKS(LT), .DCLICK_TICKS(DT),
               .REPEAT_TICKS(RT), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .clean_pb(pb_n),
        .held(held_a), .press_p(press_a), .release_p(release_a),
        .click_p(click_a), .dclick_p(dclick_a), .long_p(long_a), .repeat_p(repeat_a));

    pb_event #(.TICK_DIV(DIV), .LONG_TICKS(LT), .DCLICK_TICKS(DT),
               .REPEAT_TICKS(RT), .ACTIVE_LOW(1'b0)) dut_pos (
        .clk(clk), .rst_n(rst_n), .clean_pb(pb),
        .held(held_b), .press_p(press_b), .release_p(release_b),
        .click_p(click_b), .dclick_p(dclick_b), .long_p(long_b), .repeat_p(repeat_b));

    assign obs_a = {held_a, press_a, release_a, click_a, dclick_a, long_a, repeat_a};
    assign obs_b = {held_b, press_b, release_b, click_b, dclick_b, long_b, repeat_b};

    int n_checks = 0;
    int n_fail = 0;

    // Gesture model: absolute cycle timestamps, no prescaler or tick counter.
    typedef enum {M_IDLE, M_FIRST, M_LONG, M_WIN, M_SECOND} mode_t;
    mode_t mode;
    int t, t0;
    bit in1, in2;

    task automatic model_reset();
        mode = M_IDLE; t = 0; t0 = 0; in1 = 1'b0; in2 = 1'b0;
    endtask

    task automatic model_step(input bit p, output logic [6:0] e);
        bit lvl, prv, rise, fall;
        lvl = in1; prv = in2; in2 = in1; in1 = p; t++;
        rise = lvl & !prv;
        fall = !lvl & prv;
        e = '0;
        e[B_HELD] = lvl; e[B_PRESS] = rise; e[B_REL] = fall;
        case (mode)
            M_IDLE:   if (rise) begin mode = M_FIRST; t0 = t; end
            M_FIRST:  if (fall) begin mode = M_WIN; t0 = t; end
                      else if (t - t0 == LT * DIV) begin e[B_LONG] = 1'b1; mode = M_LONG; t0 = t; end
            M_LONG:   if (fall) mode = M_IDLE;
                      else if ((t - t0) % (RT * DIV) == 0) e[B_REP] = 1'b1;
            M_WIN:    if (rise) begin e[B_DCLK] = 1'b1; mode = M_SECOND; end
                      else if (t - t0 == DT * DIV) begin e[B_CLICK] = 1'b1; mode = M_IDLE; end
            M_SECOND: if (fall) mode = M_IDLE;
            default:  mode = M_IDLE;
        endcase
    endtask

    // Pulse tallies per scenario: count, first and last step index of each output.
    int k;
    int cnt[7], first[7], last[7];

    task automatic clear_tally();
        k = 0;
        for (int b = 0; b < 7; b++) begin cnt[b] = 0; first[b] = -1; last[b] = -1; end
    endtask

    task automatic step(input bit p, output logic [6:0] e);
        pb = p; pb_n = ~p;
        @(posedge clk); #1;
        k++;
        model_step(p, e);
        for (int b = 0; b < 7; b++) if (obs_a[b] === 1'b1) begin
            cnt[b]++; if (first[b] < 0) first[b] = k; last[b] = k;
        end
    endtask

    typedef struct { bit lvl; int len; } seg_t;
    seg_t segs[$];

    task automatic add(input bit lvl, input int len);
        seg_t s; s.lvl = lvl; s.len = len; segs.push_back(s);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pb = 1'b0; pb_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({obs_a, obs_b} !== '0) begin
            n_fail++; $display("FAIL reset_state got=%b/%b exp=0", obs_a, obs_b);
        end
        @(negedge clk); rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_short_click();
        logic [6:0] e;
        segs.delete(); add(0, 5); add(1, 20); add(0, 30);
        clear_tally();
        foreach (segs[s]) for (int i = 0; i < segs[s].len; i++) begin
            step(segs[s].lvl, e); n_checks++;
            if (obs_a !== e) begin n_fail++; $display("FAIL short_click k=%0d got=%b exp=%b", k, obs_a, e); end
        end
        n_checks++;
        if (first[B_PRESS] != 7) begin n_fail++; $display("FAIL click_press_lat got=%0d exp=7", first[B_PRESS]); end
        n_checks++;
        if (first[B_REL] != 27) begin n_fail++; $display("FAIL click_release_lat got=%0d exp=27", first[B_REL]); end
        n_checks++;
        if (first[B_CLICK] - first[B_REL] != 20 || cnt[B_CLICK] != 1) begin
            n_fail++; $display("FAIL click_lat got=%0d cnt=%0d exp=20 cnt=1", first[B_CLICK] - first[B_REL], cnt[B_CLICK]);
        end
        n_checks++;
        if (cnt[B_DCLK] + cnt[B_LONG] + cnt[B_REP] != 0) begin
            n_fail++; $display("FAIL click_extra got=%0d exp=0", cnt[B_DCLK] + cnt[B_LONG] + cnt[B_REP]);
        end
    endtask

    task automatic test_double_click();
        logic [6:0] e;
        segs.delete(); add(1, 8); add(0, 8); add(1, 8); add(0, 30);
        clear_tally();
        foreach (segs[s]) for (int i = 0; i < segs[s].len; i++) begin
            step(segs[s].lvl, e); n_checks++;
            if (obs_a !== e) begin n_fail++; $display("FAIL double_click k=%0d got=%b exp=%b", k, obs_a, e); end
        end
        n_checks++;
        if (cnt[B_DCLK] != 1 || first[B_DCLK] != last[B_PRESS] || first[B_DCLK] != 18) begin
            n_fail++; $display("FAIL dclick_align got=%0d press=%0d exp=18", first[B_DCLK], last[B_PRESS]);
        end
        n_checks++;
        if (cnt[B_CLICK] != 0 || cnt[B_PRESS] + cnt[B_REL] != 4) begin
            n_fail++; $display("FAIL dclick_counts click=%0d edges=%0d exp=0/4", cnt[B_CLICK], cnt[B_PRESS] + cnt[B_REL]);
        end
    endtask

    task automatic test_long_repeat();
        logic [6:0] e;
        segs.delete(); add(1, 100); add(0, 30);
        clear_tally();
        foreach (segs[s]) for (int i = 0; i < segs[s].len; i++) begin
            step(segs[s].lvl, e); n_checks++;
            if (obs_a !== e) begin n_fail++; $display("FAIL long_repeat k=%0d got=%b exp=%b", k, obs_a, e); end
        end
        n_checks++;
        if (first[B_LONG] - first[B_PRESS] != 40) begin
            n_fail++; $display("FAIL long_lat got=%0d exp=40", first[B_LONG] - first[B_PRESS]);
        end
        n_checks++;
        if (first[B_REP] - first[B_LONG] != 12) begin
            n_fail++; $display("FAIL repeat_first got=%0d exp=12", first[B_REP] - first[B_LONG]);
        end
        // Release lands exactly on the fifth repeat tick, which must be dropped.
        n_checks++;
        if (cnt[B_REP] != 4 || first[B_REL] - first[B_LONG] != 60) begin
            n_fail++; $display("FAIL repeat_count got=%0d rel=%0d exp=4/60", cnt[B_REP], first[B_REL] - first[B_LONG]);
        end
        n_checks++;
        if (cnt[B_CLICK] != 0) begin n_fail++; $display("FAIL long_noclick got=%0d exp=0", cnt[B_CLICK]); end
    endtask

    task automatic test_ties();
        logic [6:0] e;
        segs.delete(); add(1, 40); add(0, 30);
        clear_tally();
        foreach (segs[s]) for (int i = 0; i < segs[s].len; i++) begin
            step(segs[s].lvl, e); n_checks++;
            if (obs_a !== e) begin n_fail++; $display("FAIL tie_long k=%0d got=%b exp=%b", k, obs_a, e); end
        end
        n_checks++;
        if (cnt[B_LONG] != 0 || cnt[B_CLICK] != 1 || first[B_REL] - first[B_PRESS] != 40) begin
            n_fail++; $display("FAIL tie_long_result long=%0d click=%0d exp=0/1", cnt[B_LONG], cnt[B_CLICK]);
        end
        segs.delete(); add(1, 8); add(0, 20); add(1, 8); add(0, 30);
        clear_tally();
        foreach (segs[s]) for (int i = 0; i < segs[s].len; i++) begin
            step(segs[s].lvl, e); n_checks++;
            if (obs_a !== e) begin n_fail++; $display("FAIL tie_window k=%0d got=%b exp=%b", k, obs_a, e); end
        end
        n_checks++;
        if (cnt[B_DCLK] != 1 || cnt[B_CLICK] != 0 || first[B_DCLK] - first[B_REL] != 20) begin
            n_fail++; $display("FAIL tie_window_result dclick=%0d click=%0d exp=1/0", cnt[B_DCLK], cnt[B_CLICK]);
        end
    endtask

    task automatic test_reset_mid_gesture();
        logic [6:0] e;
        clear_tally();
        for (int i = 0; i < 50; i++) begin
            step(1'b1, e); n_checks++;
            if (obs_a !== e) begin n_fail++; $display("FAIL pre_reset k=%0d got=%b exp=%b", k, obs_a, e); end
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({obs_a, obs_b} !== '0) begin
            n_fail++; $display("FAIL async_reset got=%b/%b exp=0", obs_a, obs_b);
        end
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        clear_tally();
        for (int i = 0; i < 50; i++) begin
            step(1'b1, e); n_checks++;
            if (obs_a !== e) begin n_fail++; $display("FAIL post_reset k=%0d got=%b exp=%b", k, obs_a, e); end
        end
        n_checks++;
        if (first[B_PRESS] != 2 || first[B_LONG] - first[B_PRESS] != 40) begin
            n_fail++; $display("FAIL held_through_reset press=%0d long=%0d exp=2/42", first[B_PRESS], first[B_LONG]);
        end
        for (int i = 0; i < 30; i++) begin
            step(1'b0, e); n_checks++;
            if (obs_a !== e) begin n_fail++; $display("FAIL reset_release k=%0d got=%b exp=%b", k, obs_a, e); end
        end
    endtask

    task automatic test_polarity();
        logic [6:0] e;
        segs.delete(); add(0, 5); add(1, 20); add(0, 30);
        clear_tally();
        foreach (segs[s]) for (int i = 0; i < segs[s].len; i++) begin
            step(segs[s].lvl, e); n_checks++;
            if (obs_b !== e || obs_b !== obs_a) begin
                n_fail++; $display("FAIL polarity k=%0d got=%b low=%b exp=%b", k, obs_b, obs_a, e);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] e;
        bit lvl;
        segs.delete();
        lvl = 1'b1;
        for (int g = 0; g < 40; g++) begin
            add(lvl, int'($urandom_range(1, 50)));
            lvl = !lvl;
        end
        add(0, 30);
        clear_tally();
        foreach (segs[s]) for (int i = 0; i < segs[s].len; i++) begin
            step(segs[s].lvl, e); n_checks++;
            if (obs_a !== e || obs_b !== e) begin
                n_fail++; $display("FAIL random k=%0d got=%b/%b exp=%b", k, obs_a, obs_b, e);
            end
            n_checks++;
            if ($countones(obs_a[3:0]) > 1) begin
                n_fail++; $display("FAIL exclusive_events k=%0d got=%b exp=onehot0", k, obs_a[3:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_short_click();
        test_double_click();
        test_long_repeat();
        test_ties();
        test_reset_mid_gesture();
        test_polarity();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
